// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage sitting directly downstream of the PC register.
//   Each cycle it decides whether to read instruction memory at the current PC.
//   The read is made only when the small fetch FIFO still has a free slot once
//   every outstanding response has landed. Returned words are buffered with
//   their address and presented to decode through a valid/ready handshake.
//   The stage also computes the PC register's next value:
//     redirect target   when i_redirect is high
//     PC + 1            when a read is issued (wraps mod 2^WIDTH)
//     hold              otherwise
//
//   Optional feature macro: FETCH_PERF_EN
//     When it is defined, the stage adds the two saturating 16-bit performance
//     counters o_stall_cnt and o_flush_cnt.
//
//   Ports
//     i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//     i_pc / o_pc_next        current PC in, next PC out to the PC register
//     i_redirect(_pc)         branch/jump taken and its target
//     o_imem_req/o_imem_addr  instruction memory read request and address
//     i_imem_rvalid/_rdata    read response, exactly one cycle after a request
//     o_instr_valid/o_instr/o_instr_pc, i_instr_ready   decode handshake
//     o_stall_cnt/o_flush_cnt (FETCH_PERF_EN only)     perf counters
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int               WIDTH     = 14,
  parameter int               INSTR_W   = 16,
  parameter logic [WIDTH-1:0] RESET_VEC = 14'h2000,
  parameter int               DEPTH     = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [WIDTH-1:0]   i_pc,
  output logic [WIDTH-1:0]   o_pc_next,
  input  logic               i_redirect,
  input  logic [WIDTH-1:0]   i_redirect_pc,
  output logic               o_imem_req,
  output logic [WIDTH-1:0]   o_imem_addr,
  input  logic               i_imem_rvalid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_instr_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [WIDTH-1:0]   o_instr_pc,
  input  logic               i_instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        o_stall_cnt,
  output logic [15:0]        o_flush_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e             state_r;
  state_e             state_nxt_s;
  logic [CNT_W-1:0]   count_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic               inflight_r;
  logic [WIDTH-1:0]   inflight_pc_r;
  logic [INSTR_W-1:0] data_mem_r [DEPTH];
  logic [WIDTH-1:0]   pc_mem_r   [DEPTH];

  logic [CNT_W:0]     occupancy_s;
  logic               req_s;
  logic               valid_s;
  logic               push_s;
  logic               pop_s;
  logic               full_s;

  // The credit includes the outstanding response, so a response always finds a free slot.
  assign occupancy_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
  assign full_s      = (count_r == CNT_W'(DEPTH));

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a redirect always restarts through FLUSH
  always_comb begin
    state_nxt_s = state_r;
    if (i_redirect) begin
      state_nxt_s = ST_FLUSH;
    end else begin
      case (state_r)
        ST_BOOT:  state_nxt_s = ST_RUN;
        ST_RUN:   state_nxt_s = ST_RUN;
        ST_FLUSH: state_nxt_s = ST_RUN;
        default:  state_nxt_s = ST_BOOT;
      endcase
    end
  end

  // FSM outputs: request, handshake, FIFO push/pop and next PC
  always_comb begin
    req_s     = 1'b0;
    valid_s   = 1'b0;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    o_pc_next = i_pc;
    if ((state_r != ST_BOOT) && !i_redirect && (occupancy_s < DEPTH_C)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
    // A redirect hides the head so decode cannot consume a word that is being flushed.
    if ((count_r != {CNT_W{1'b0}}) && !i_redirect) begin
      valid_s = 1'b1;
    end else begin
      valid_s = 1'b0;
    end
    // A response that lands during FLUSH belongs to the abandoned path.
    if (i_imem_rvalid && (state_r != ST_FLUSH)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    pop_s = valid_s && i_instr_ready;
    if (!i_rst_n) begin
      o_pc_next = RESET_VEC;
    end else if (i_redirect) begin
      o_pc_next = i_redirect_pc;
    end else if (req_s) begin
      o_pc_next = i_pc + WIDTH'(1'b1);
    end else begin
      o_pc_next = i_pc;
    end
  end

  assign o_imem_req    = req_s;
  assign o_imem_addr   = i_pc;
  assign o_instr_valid = valid_s;
  assign o_instr       = data_mem_r[rd_ptr_r];
  assign o_instr_pc    = pc_mem_r[rd_ptr_r];

  // Outstanding-request tracker: one-cycle memory latency means at most one is in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight_r    <= 1'b0;
      inflight_pc_r <= {WIDTH{1'b0}};
    end else begin
      inflight_r <= req_s;
      if (req_s) begin
        inflight_pc_r <= i_pc;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO and takes priority
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_r  <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else if (i_redirect) begin
      count_r  <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero out of reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= {INSTR_W{1'b0}};
        pc_mem_r[i]   <= {WIDTH{1'b0}};
      end
    end else if (push_s && !i_redirect) begin
      data_mem_r[wr_ptr_r] <= i_imem_rdata;
      pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  // Saturating counters: decode back-pressure cycles and accepted redirects
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_r <= 16'h0000;
      flush_cnt_r <= 16'h0000;
    end else begin
      if (valid_s && !i_instr_ready && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end
      if (i_redirect && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'h0001;
      end
    end
  end

  assign o_stall_cnt = stall_cnt_r;
  assign o_flush_cnt = flush_cnt_r;
`endif

  fetch_stage_chk u_chk (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .push   (push_s && !i_redirect),
    .full   (full_s)
  );

endmodule

// -----------------------------------------------------------------------------
// fetch_stage_chk
//   Property checker for fetch_stage: a response must never be written into a
//   full FIFO, which the request credit rule is meant to make impossible.
//   Ports: clk, rst_n, push (effective FIFO write), full (FIFO at capacity).
// -----------------------------------------------------------------------------
module fetch_stage_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic full
);

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. The bench plays the PC register (i_pc
//   follows o_pc_next) and a one-cycle-latency instruction memory. A reference
//   model holds requested words in a pending queue and delivered words in a
//   FIFO queue, and every cycle it checks the request, next PC and head
//   handshake against those queues.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [13:0] i_pc;
  logic [13:0] o_pc_next;
  logic        i_redirect;
  logic [13:0] i_redirect_pc;
  logic        o_imem_req;
  logic [13:0] o_imem_addr;
  logic        i_imem_rvalid;
  logic [15:0] i_imem_rdata;
  logic        o_instr_valid;
  logic [15:0] o_instr;
  logic [13:0] o_instr_pc;
  logic        i_instr_ready;
`ifdef FETCH_PERF_EN
  logic [15:0] o_stall_cnt;
  logic [15:0] o_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [13:0] a;
  } ent_t;

  ent_t        pend_q[$];
  ent_t        fifo_q[$];
  int          m_state;
  int          m_stall;
  int          m_flush;
  logic [13:0] pc_q;
  logic [13:0] obs_pcn;
  logic [13:0] first_pc;
  bit          track;

  fetch_stage dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_pc          (i_pc),
    .o_pc_next     (o_pc_next),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .i_instr_ready (i_instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .o_stall_cnt   (o_stall_cnt),
    .o_flush_cnt   (o_flush_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] mem_word(input logic [13:0] a);
    return 16'hC000 ^ {2'b00, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check at the falling edge, advance model, then memory/PC update.
  task automatic cycle(input logic rdy, input logic redir, input logic [13:0] tgt);
    logic        exp_req;
    logic        exp_valid;
    logic [13:0] exp_pcn;
    logic        s_req;
    logic [13:0] s_addr;
    logic [13:0] s_pcn;
    i_instr_ready = rdy;
    i_redirect    = redir;
    i_redirect_pc = tgt;
    @(negedge i_clk);
    exp_req   = (m_state != 0) && !redir && ((fifo_q.size() + pend_q.size()) < 2);
    exp_pcn   = redir ? tgt : (exp_req ? pc_q + 14'd1 : pc_q);
    exp_valid = (fifo_q.size() > 0) && !redir;
    chk("req", o_imem_req, exp_req);
    chk("addr", o_imem_addr, pc_q);
    chk("pc_next", o_pc_next, exp_pcn);
    chk("valid", o_instr_valid, exp_valid);
    if (exp_valid) begin
      chk("instr", o_instr, fifo_q[0].d);
      chk("instr_pc", o_instr_pc, fifo_q[0].a);
    end
    s_req   = o_imem_req;
    s_addr  = o_imem_addr;
    s_pcn   = o_pc_next;
    obs_pcn = o_pc_next;
    if (exp_valid && !rdy) m_stall++;
    if (redir) m_flush++;
    if (redir) begin
      fifo_q.delete();
      pend_q.delete();
      m_state = 2;
    end else begin
      if (exp_valid && rdy) begin
        if (track) begin
          first_pc = o_instr_pc;
          track    = 1'b0;
        end
        void'(fifo_q.pop_front());
      end
      if ((pend_q.size() > 0) && (m_state != 2)) fifo_q.push_back(pend_q[0]);
      pend_q.delete();
      if (exp_req) pend_q.push_back('{d: mem_word(pc_q), a: pc_q});
      m_state = 1;
    end
    @(posedge i_clk);
    #1;
    i_imem_rvalid = s_req;
    i_imem_rdata  = mem_word(s_addr);
    pc_q          = s_pcn;
    i_pc          = pc_q;
  endtask

  initial begin
    i_rst_n       = 1'b0;
    pc_q          = 14'h2000;
    i_pc          = 14'h2000;
    i_redirect    = 1'b0;
    i_redirect_pc = 14'h0000;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 16'h0000;
    i_instr_ready = 1'b0;
    m_state       = 0;
    m_stall       = 0;
    m_flush       = 0;
    track         = 1'b0;
    first_pc      = 14'h0000;
    obs_pcn       = 14'h0000;

    // Reset values
    @(negedge i_clk);
    chk("rst_valid", o_instr_valid, 1'b0);
    chk("rst_instr", o_instr, 16'h0000);
    chk("rst_instr_pc", o_instr_pc, 14'h0000);
    chk("rst_req", o_imem_req, 1'b0);
    chk("rst_pc_next", o_pc_next, 14'h2000);
`ifdef FETCH_PERF_EN
    chk("rst_stall_cnt", o_stall_cnt, 16'h0000);
    chk("rst_flush_cnt", o_flush_cnt, 16'h0000);
`endif
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Sequential fetch with decode always ready
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 14'h0000);

    // Decode stalled for six cycles, then drains in order
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 14'h0000);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 14'h0000);

    // Redirect while one word is buffered and one response is in flight
    cycle(1'b0, 1'b1, 14'h2080);
    cycle(1'b0, 1'b0, 14'h0000);
    cycle(1'b0, 1'b0, 14'h0000);
    track = 1'b1;
    cycle(1'b0, 1'b1, 14'h2100);
    chk("redir_pc_next", obs_pcn, 14'h2100);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 14'h0000);
    chk("first_after_redir", first_pc, 14'h2100);

    // Redirect coinciding with ready on a valid head: the head is not accepted
    for (int i = 0; (i < 10) && (fifo_q.size() == 0); i++) cycle(1'b1, 1'b0, 14'h0000);
    chk("head_present", o_instr_valid, 1'b1);
    track = 1'b1;
    cycle(1'b1, 1'b1, 14'h2200);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 14'h0000);
    chk("head_flushed", first_pc, 14'h2200);

    // PC wrap at the top of the address space
    track = 1'b1;
    cycle(1'b1, 1'b1, 14'h3FFF);
    cycle(1'b1, 1'b0, 14'h0000);
    chk("wrap_pc_next", obs_pcn, 14'h0000);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 14'h0000);
    chk("wrap_tag", first_pc, 14'h3FFF);

    // Fill the FIFO, check counters, then reset asynchronously mid-stream
    for (int i = 0; (i < 10) && (fifo_q.size() < 2); i++) cycle(1'b0, 1'b0, 14'h0000);
    chk("pre_rst_valid", o_instr_valid, 1'b1);
`ifdef FETCH_PERF_EN
    chk("stall_cnt", o_stall_cnt, m_stall[15:0]);
    chk("flush_cnt", o_flush_cnt, m_flush[15:0]);
`endif
    i_rst_n       = 1'b0;
    i_imem_rvalid = 1'b0;
    #1;
    chk("arst_valid", o_instr_valid, 1'b0);
    chk("arst_instr", o_instr, 16'h0000);
    chk("arst_instr_pc", o_instr_pc, 14'h0000);
    chk("arst_req", o_imem_req, 1'b0);
    chk("arst_pc_next", o_pc_next, 14'h2000);
`ifdef FETCH_PERF_EN
    chk("arst_stall_cnt", o_stall_cnt, 16'h0000);
`endif
    @(posedge i_clk);
    #1;
    pc_q    = 14'h2000;
    i_pc    = pc_q;
    m_state = 0;
    m_stall = 0;
    m_flush = 0;
    fifo_q.delete();
    pend_q.delete();
    i_rst_n = 1'b1;
    // BOOT cycle without a request, then normal fetch
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 14'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
